// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchroniser, debounce, press/release pulses and hold-to-repeat
module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic               any_press
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DELAY = 2'd1,
        R_RPT   = 2'd2
    } rstate_t;

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, release_q, repeat_q;
    logic [NUM_BTN-1:0] repeat_d;
    logic               any_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            any_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
            repeat_q  <= repeat_d;
            any_q     <= |(level_d & ~level_q);
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [DW-1:0] cnt_q, cnt_d;
        logic          lvl_d;
        rstate_t       state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          rpt_d;

        // Any sample equal to the current level restarts the debounce window.
        always_comb begin
            cnt_d = '0;
            lvl_d = level_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q == DB_LAST) begin
                    lvl_d = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                state_q <= R_IDLE;
                rcnt_q  <= '0;
            end else begin
                cnt_q   <= cnt_d;
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        // The FSM follows the next level so DELAY starts on the press edge itself.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            if (!lvl_d) begin
                state_d = R_IDLE;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    R_IDLE: begin
                        state_d = R_DELAY;
                        rcnt_d  = '0;
                    end
                    R_DELAY: begin
                        if (!repeat_en) begin
                            rcnt_d = '0;
                        end else if (rcnt_q == RD_LAST) begin
                            state_d = R_RPT;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    R_RPT: begin
                        if (!repeat_en) begin
                            state_d = R_DELAY;
                            rcnt_d  = '0;
                        end else if (rcnt_q == RR_LAST) begin
                            rcnt_d = '0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = R_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_comb begin
            rpt_d = 1'b0;
            if (lvl_d && repeat_en) begin
                rpt_d = ((state_q == R_DELAY) && (rcnt_q == RD_LAST)) ||
                        ((state_q == R_RPT)   && (rcnt_q == RR_LAST));
            end
        end

        assign level_d[i]  = lvl_d;
        assign repeat_d[i] = rpt_d;
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign any_press   = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic          repeat_en = 1'b0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic          any_press;

    button_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .repeat_en(repeat_en),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .any_press(any_press)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference: raw history per edge; level flips once DB consecutive synchronised
    // samples disagree; repeats are timed arithmetically from the last press or disable.
    logic [NB-1:0] hist[$];
    int            anchor[NB];
    logic [NB-1:0] m_lvl, m_prs, m_rel, m_rpt;
    int            rep_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic s_at(input int idx, input int b);
        logic [NB-1:0] v;
        if (idx < 0) return 1'b0;
        v = hist[idx];
        return v[b];
    endfunction

    task automatic model_clear();
        hist.delete();
        m_lvl = '0; m_prs = '0; m_rel = '0; m_rpt = '0;
        for (int b = 0; b < NB; b++) anchor[b] = 0;
    endtask

    task automatic model_step();
        int e;
        bit chg;
        hist.push_back(btn_raw);
        e = hist.size() - 1;
        m_prs = '0; m_rel = '0; m_rpt = '0;
        for (int b = 0; b < NB; b++) begin
            chg = 1'b1;
            for (int k = 0; k < DB; k++)
                if (s_at(e - k - 2, b) == m_lvl[b]) chg = 1'b0;
            if (chg) begin
                m_lvl[b] = ~m_lvl[b];
                if (m_lvl[b]) begin
                    m_prs[b] = 1'b1;
                    anchor[b] = e;
                end else begin
                    m_rel[b] = 1'b1;
                end
            end else if (m_lvl[b]) begin
                if (!repeat_en) anchor[b] = e;
                else if ((e - anchor[b]) >= RD && ((e - anchor[b] - RD) % RR) == 0) m_rpt[b] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_clear();
        #1;
        chk("level", btn_level, m_lvl);
        chk("press", btn_press, m_prs);
        chk("release", btn_release, m_rel);
        chk("repeat", btn_repeat, m_rpt);
        chk("any_press", any_press, |m_prs);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst_level", btn_level, 0);
        chk("rst_pulses", {btn_press, btn_release, btn_repeat}, 0);
        chk("rst_any", any_press, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic watch(input int n, input int b, output int fp, output int fr, output int np);
        fp = -1; fr = -1; np = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (btn_press[b]) begin
                np++;
                if (fp < 0) fp = k;
            end
            if (btn_release[b] && fr < 0) fr = k;
            if (btn_repeat[b]) rep_q.push_back(k);
        end
    endtask

    typedef struct {
        logic [NB-1:0] raw;
        int            cyc;
        logic [NB-1:0] exp_lvl;
        int            exp_np;
        int            exp_nr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int fp, fr, np, np2, any_n, tp, tr;
        model_clear();

        // reset with all buttons held, then release of reset
        btn_raw = 5'h1F;
        async_reset();
        fp = -1; any_n = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (btn_press == 5'h1F && fp < 0) fp = k;
            if (any_press) any_n++;
        end
        chk("held_reset_press_edge", fp, 6);
        chk("held_reset_any_cycles", any_n, 1);
        btn_raw = '0;
        repeat (10) tick();

        // clean press on button 4
        btn_raw[4] = 1'b1;
        watch(30, 4, fp, fr, np);
        chk("clean_press_edge", fp, 6);
        chk("clean_press_count", np, 1);
        btn_raw[4] = 1'b0;
        watch(10, 4, fp, fr, np);
        chk("clean_release_edge", fr, 6);

        // bouncing button 0
        np2 = 0;
        for (int i = 0; i < 6; i++) begin
            btn_raw[0] = ~btn_raw[0];
            watch(2, 0, fp, fr, np);
            np2 += np;
        end
        btn_raw[0] = 1'b1;
        watch(12, 0, fp, fr, np);
        chk("bounce_press_edge", fp, 6);
        chk("bounce_press_count", np + np2, 1);
        btn_raw[0] = 1'b0;
        repeat (10) tick();

        // auto-repeat on button 3
        repeat_en = 1'b1;
        rep_q.delete();
        btn_raw[3] = 1'b1;
        watch(43, 3, fp, fr, np);
        chk("rpt_press_edge", fp, 6);
        chk("rpt_count", rep_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("rpt_offset", (rep_q.size() > i) ? rep_q[i] - fp : -1, RD + i * RR);
        rep_q.delete();
        btn_raw[3] = 1'b0;
        watch(30, 3, fp, fr, np);
        chk("rpt_after_release", rep_q.size(), 0);

        repeat_en = 1'b0;
        btn_raw[3] = 1'b1;
        watch(50, 3, fp, fr, np);
        chk("norpt_press_edge", fp, 6);
        chk("norpt_count", rep_q.size(), 0);
        btn_raw[3] = 1'b0;
        repeat (10) tick();

        // reset while button 2 is in the repeating state
        repeat_en = 1'b1;
        btn_raw[2] = 1'b1;
        rep_q.delete();
        watch(30, 2, fp, fr, np);
        chk("pre_reset_rpt", rep_q.size(), 1);
        async_reset();
        rep_q.delete();
        watch(30, 2, fp, fr, np);
        chk("midhold_press_edge", fp, 6);
        chk("midhold_first_rpt", (rep_q.size() > 0) ? rep_q[0] - fp : -1, RD);
        btn_raw = '0;
        repeat_en = 1'b0;
        repeat (10) tick();

        // table of held patterns: level at end, press/release pulse totals
        vecs[0] = '{5'h00,  8, 5'h00, 0, 0};
        vecs[1] = '{5'h10, 10, 5'h10, 1, 0};
        vecs[2] = '{5'h00,  2, 5'h10, 0, 0};
        vecs[3] = '{5'h10,  8, 5'h10, 0, 0};
        vecs[4] = '{5'h00, 10, 5'h00, 0, 1};
        vecs[5] = '{5'h09, 10, 5'h09, 2, 0};
        vecs[6] = '{5'h0B,  3, 5'h09, 0, 0};
        vecs[7] = '{5'h09, 10, 5'h09, 0, 0};
        vecs[8] = '{5'h00, 10, 5'h00, 0, 2};
        for (int v = 0; v < 9; v++) begin
            btn_raw = vecs[v].raw;
            tp = 0; tr = 0;
            for (int k = 0; k < vecs[v].cyc; k++) begin
                tick();
                tp += $countones(btn_press);
                tr += $countones(btn_release);
            end
            chk($sformatf("vec%0d_level", v), btn_level, vecs[v].exp_lvl);
            chk($sformatf("vec%0d_presses", v), tp, vecs[v].exp_np);
            chk($sformatf("vec%0d_releases", v), tr, vecs[v].exp_nr);
        end

        // randomised run against the reference model
        repeat_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 15) == 0) btn_raw[b] = ~btn_raw[b];
            if ($urandom_range(0, 63) == 0) repeat_en = ~repeat_en;
            if ($urandom_range(0, 999) == 0) async_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
